// File: rtl/ball_motion_ctrl_pkg.sv
// Shared types and constants for the ball motion controller (package ball_ctrl_pkg).
// Build option: define BALL_CTRL_ACCEL_EN to enable held-key acceleration.
package ball_ctrl_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEY  = 2'd1,
    AUTO = 2'd2
  } state_t;

  localparam logic [7:0] KC_UP    = 8'h1A;
  localparam logic [7:0] KC_DOWN  = 8'h16;
  localparam logic [7:0] KC_LEFT  = 8'h04;
  localparam logic [7:0] KC_RIGHT = 8'h07;

  localparam int MOTION_W = 10;

  typedef struct packed {
    logic signed [MOTION_W-1:0] x;
    logic signed [MOTION_W-1:0] y;
  } motion_t;

endpackage

// File: rtl/ball_motion_ctrl_if.sv
// Control bus between the keyboard/autopilot side and the ball motion controller.
// The controller takes the slave modport; the input sources take the master modport.
interface ball_motion_ctrl_if;
  import ball_ctrl_pkg::*;

  logic [7:0]          keycode;
  logic                auto_req;
  logic [1:0]          auto_dir;
  logic                auto_gnt;
  logic [MOTION_W-1:0] Motion_X;
  logic [MOTION_W-1:0] Motion_Y;
  logic [1:0]          owner;

  modport master (
    output keycode, auto_req, auto_dir,
    input  auto_gnt, Motion_X, Motion_Y, owner
  );

  modport slave (
    input  keycode, auto_req, auto_dir,
    output auto_gnt, Motion_X, Motion_Y, owner
  );

endinterface

// File: rtl/ball_motion_ctrl_key_decode.sv
// Combinational HID keycode decoder: maps the four arrow-like keys to a direction.
// Any other code, including 0x00, reports no valid key.
module key_decode
  import ball_ctrl_pkg::*;
(
  input  logic [7:0] i_keycode,
  output logic       o_valid,
  output dir_t       o_dir
);

  always_comb begin
    o_valid = 1'b1;
    o_dir   = DIR_UP;
    case (i_keycode)
      KC_UP:    o_dir = DIR_UP;
      KC_DOWN:  o_dir = DIR_DOWN;
      KC_LEFT:  o_dir = DIR_LEFT;
      KC_RIGHT: o_dir = DIR_RIGHT;
      default:  o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Arbitrates ball motion between keyboard (priority, with timeout) and autopilot.
// Build option: BALL_CTRL_ACCEL_EN enables held-key acceleration up to MAX_STEP.
module ball_motion_ctrl
  import ball_ctrl_pkg::*;
#(
  parameter int KEY_TIMEOUT  = 60,
  parameter int STEP         = 1,
  parameter int MAX_STEP     = 4,
  parameter int ACCEL_FRAMES = 8
) (
  input  logic               frame_clk,
  input  logic               Reset_n,
  ball_motion_ctrl_if.slave  bus
);

  localparam int CNT_W = (KEY_TIMEOUT < 1) ? 1 : $clog2(KEY_TIMEOUT + 1);
  localparam logic [MOTION_W-1:0] BASE_STEP = MOTION_W'(STEP);

  function automatic motion_t dir_motion(input dir_t d, input logic [MOTION_W-1:0] s);
    motion_t                    m;
    logic signed [MOTION_W-1:0] ss;
    ss  = $signed(s);
    m.x = '0;
    m.y = '0;
    case (d)
      DIR_UP:   m.y = -ss;
      DIR_DOWN: m.y = ss;
      DIR_LEFT: m.x = -ss;
      default:  m.x = ss;
    endcase
    return m;
  endfunction

  logic                w_key_vld;
  dir_t                w_key_dir;
  logic [MOTION_W-1:0] w_key_step;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  motion_t             r_motion, w_motion_nxt;

  key_decode u_key_decode (
    .i_keycode (bus.keycode),
    .o_valid   (w_key_vld),
    .o_dir     (w_key_dir)
  );

`ifdef BALL_CTRL_ACCEL_EN
  localparam int ACC_W = (ACCEL_FRAMES <= 1) ? 1 : $clog2(ACCEL_FRAMES);

  function automatic logic [MOTION_W-1:0] step_inc(input logic [MOTION_W-1:0] s);
    if (s >= MOTION_W'(MAX_STEP)) return MOTION_W'(MAX_STEP);
    return s + MOTION_W'(1);
  endfunction

  logic [MOTION_W-1:0] r_step, w_step_nxt;
  logic [ACC_W-1:0]    r_acc, w_acc_nxt;
  logic                r_prev_vld;
  dir_t                r_prev_dir;
  logic                w_same_key;

  // Acceleration tracks the decoded key every frame, independent of ownership.
  always_comb begin
    w_same_key = w_key_vld && r_prev_vld && (w_key_dir == r_prev_dir);
    w_step_nxt = BASE_STEP;
    w_acc_nxt  = '0;
    if (w_same_key) begin
      if (r_acc >= ACC_W'(ACCEL_FRAMES - 1)) begin
        w_step_nxt = step_inc(r_step);
      end else begin
        w_step_nxt = r_step;
        w_acc_nxt  = r_acc + ACC_W'(1);
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      r_step     <= BASE_STEP;
      r_acc      <= '0;
      r_prev_vld <= 1'b0;
      r_prev_dir <= DIR_UP;
    end else begin
      r_step     <= w_step_nxt;
      r_acc      <= w_acc_nxt;
      r_prev_vld <= w_key_vld;
      r_prev_dir <= w_key_dir;
    end
  end

  assign w_key_step = w_step_nxt;
`else
  logic w_unused_accel_cfg;
  assign w_unused_accel_cfg = ^{MAX_STEP, ACCEL_FRAMES};
  assign w_key_step         = BASE_STEP;
`endif

  // Next-state: keyboard always wins; autopilot motion always uses the base step.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_motion_nxt = r_motion;
    case (r_state)
      IDLE: begin
        if (w_key_vld) begin
          w_state_nxt  = KEY;
          w_cnt_nxt    = CNT_W'(KEY_TIMEOUT);
          w_motion_nxt = dir_motion(w_key_dir, w_key_step);
        end else if (bus.auto_req) begin
          w_state_nxt  = AUTO;
          w_motion_nxt = dir_motion(dir_t'(bus.auto_dir), BASE_STEP);
        end
      end
      KEY: begin
        if (w_key_vld) begin
          w_cnt_nxt    = CNT_W'(KEY_TIMEOUT);
          w_motion_nxt = dir_motion(w_key_dir, w_key_step);
        end else if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      AUTO: begin
        if (w_key_vld) begin
          w_state_nxt  = KEY;
          w_cnt_nxt    = CNT_W'(KEY_TIMEOUT);
          w_motion_nxt = dir_motion(w_key_dir, w_key_step);
        end else if (!bus.auto_req) begin
          w_state_nxt = IDLE;
        end else begin
          w_motion_nxt = dir_motion(dir_t'(bus.auto_dir), BASE_STEP);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_motion <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_motion <= w_motion_nxt;
    end
  end

  assign bus.auto_gnt = (r_state == AUTO);
  assign bus.owner    = r_state;
  assign bus.Motion_X = r_motion.x;
  assign bus.Motion_Y = r_motion.y;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed, table-driven bench for ball_motion_ctrl plus hand-written multi-frame sequences.
// Acceleration expectations follow BALL_CTRL_ACCEL_EN when it is defined for the build.
module tb_ball_motion_ctrl;

  logic frame_clk = 1'b0;
  logic rst_n     = 1'b0;

  ball_motion_ctrl_if bus ();

  ball_motion_ctrl dut (
    .frame_clk (frame_clk),
    .Reset_n   (rst_n),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic       rst_n;
    logic [7:0] key;
    logic       req;
    logic [1:0] dir;
    logic       gnt;
    logic [1:0] own;
    logic [9:0] mx;
    logic [9:0] my;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic frame(input logic rn, input logic [7:0] k, input logic rq, input logic [1:0] d);
    rst_n        = rn;
    bus.keycode  = k;
    bus.auto_req = rq;
    bus.auto_dir = d;
    @(posedge frame_clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {9'd0, bus.auto_gnt, bus.owner, bus.Motion_X, bus.Motion_Y};
  endfunction

  function automatic logic [31:0] exp_outs(input logic g, input logic [1:0] o,
                                           input logic [9:0] x, input logic [9:0] y);
    return {9'd0, g, o, x, y};
  endfunction

  int exp_step;

  initial begin
    bus.keycode  = 8'h00;
    bus.auto_req = 1'b0;
    bus.auto_dir = 2'd0;

    //          rst   key    req  dir    gnt  own    Motion_X  Motion_Y
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 10'h000, 10'h000};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 10'h000, 10'h000};
    vecs[2]  = '{1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 10'h000, 10'h000};
    vecs[3]  = '{1'b1, 8'h07, 1'b0, 2'd0, 1'b0, 2'd1, 10'h001, 10'h000};
    vecs[4]  = '{1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 2'd1, 10'h001, 10'h000};
    vecs[5]  = '{1'b1, 8'h99, 1'b0, 2'd0, 1'b0, 2'd1, 10'h001, 10'h000};
    vecs[6]  = '{1'b1, 8'h1A, 1'b0, 2'd0, 1'b0, 2'd1, 10'h000, 10'h3FF};
    vecs[7]  = '{1'b1, 8'h16, 1'b0, 2'd0, 1'b0, 2'd1, 10'h000, 10'h001};
    vecs[8]  = '{1'b1, 8'h04, 1'b0, 2'd0, 1'b0, 2'd1, 10'h3FF, 10'h000};
    vecs[9]  = '{1'b1, 8'h04, 1'b1, 2'd3, 1'b0, 2'd1, 10'h3FF, 10'h000};
    vecs[10] = '{1'b1, 8'h00, 1'b1, 2'd3, 1'b0, 2'd1, 10'h3FF, 10'h000};
    vecs[11] = '{1'b0, 8'h07, 1'b1, 2'd3, 1'b0, 2'd0, 10'h000, 10'h000};
    vecs[12] = '{1'b1, 8'h00, 1'b1, 2'd0, 1'b1, 2'd2, 10'h000, 10'h3FF};
    vecs[13] = '{1'b1, 8'h00, 1'b1, 2'd3, 1'b1, 2'd2, 10'h001, 10'h000};
    vecs[14] = '{1'b1, 8'h00, 1'b1, 2'd2, 1'b1, 2'd2, 10'h3FF, 10'h000};
    vecs[15] = '{1'b1, 8'h00, 1'b1, 2'd1, 1'b1, 2'd2, 10'h000, 10'h001};
    vecs[16] = '{1'b1, 8'h04, 1'b1, 2'd1, 1'b0, 2'd1, 10'h3FF, 10'h000};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 10'h000, 10'h000};
    vecs[18] = '{1'b1, 8'h00, 1'b1, 2'd3, 1'b1, 2'd2, 10'h001, 10'h000};
    vecs[19] = '{1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 10'h001, 10'h000};
    vecs[20] = '{1'b1, 8'h00, 1'b0, 2'd2, 1'b0, 2'd0, 10'h001, 10'h000};
    vecs[21] = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 10'h000, 10'h000};

    for (int i = 0; i < NV; i++) begin
      frame(vecs[i].rst_n, vecs[i].key, vecs[i].req, vecs[i].dir);
      chk($sformatf("vec%0d", i), outs(),
          exp_outs(vecs[i].gnt, vecs[i].own, vecs[i].mx, vecs[i].my));
    end

    // Keyboard timeout: one key frame, then exactly 60 idle frames back to IDLE.
    frame(1'b1, 8'h00, 1'b0, 2'd0);
    frame(1'b1, 8'h07, 1'b0, 2'd0);
    chk("to_key", outs(), exp_outs(1'b0, 2'd1, 10'h001, 10'h000));
    repeat (59) frame(1'b1, 8'h00, 1'b0, 2'd0);
    chk("to_59", outs(), exp_outs(1'b0, 2'd1, 10'h001, 10'h000));
    frame(1'b1, 8'h00, 1'b0, 2'd0);
    chk("to_60", outs(), exp_outs(1'b0, 2'd0, 10'h001, 10'h000));
    repeat (5) frame(1'b1, 8'h00, 1'b0, 2'd0);
    chk("to_sat", outs(), exp_outs(1'b0, 2'd0, 10'h001, 10'h000));

    // Reset while the autopilot owns motion.
    frame(1'b1, 8'h00, 1'b1, 2'd1);
    chk("auto_on", outs(), exp_outs(1'b1, 2'd2, 10'h000, 10'h001));
    frame(1'b0, 8'h00, 1'b1, 2'd1);
    chk("rst_auto", outs(), exp_outs(1'b0, 2'd0, 10'h000, 10'h000));

    // Held right key for 40 frames, then release and re-press.
    frame(1'b1, 8'h00, 1'b0, 2'd0);
    exp_step = 1;
    for (int f = 0; f < 40; f++) begin
      frame(1'b1, 8'h07, 1'b0, 2'd0);
`ifdef BALL_CTRL_ACCEL_EN
      exp_step = (1 + f / 8 > 4) ? 4 : 1 + f / 8;
`else
      exp_step = 1;
`endif
      chk($sformatf("hold%0d", f), {22'd0, bus.Motion_X}, 32'(exp_step));
    end
    frame(1'b1, 8'h00, 1'b0, 2'd0);
    chk("release", outs(), exp_outs(1'b0, 2'd1, 10'(exp_step), 10'h000));
    frame(1'b1, 8'h07, 1'b0, 2'd0);
    chk("repress", outs(), exp_outs(1'b0, 2'd1, 10'h001, 10'h000));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
